// File: rtl/matriz_determ4x4_seq_pkg.sv
// Shared definitions for the 4x4 determinant unit: matrix packing geometry,
// FSM state encoding and the element bit-offset helper.
package matriz_determ4x4_seq_pkg;

    localparam int ELEM_W     = 8;
    localparam int ROW_STRIDE = 40;
    localparam int MAT_W      = 200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Bit offset of element (i,j) inside a packed 5x5 matrix vector
    function automatic int elem(input int i, input int j);
        return i * ROW_STRIDE + j * ELEM_W;
    endfunction

endpackage

// File: rtl/matriz_determ4x4_seq_determ3x3.sv
// Combinational 3x3 determinant of the top-left 3x3 of a packed 5x5 matrix.
// Produces the low 8 bits of the exact result plus an out-of-range flag.
module matriz_determ3x3
    import matriz_determ4x4_seq_pkg::*;
(
    input  logic               clk,
    input  logic [MAT_W-1:0]   matriz_A,
    output logic [ELEM_W-1:0]  det,
    output logic               overflow
);

    localparam logic signed [25:0] MAX8 = 26'sd127;
    localparam logic signed [25:0] MIN8 = -26'sd128;

    logic signed [25:0] e [3][3];
    logic signed [25:0] cof0, cof1, cof2;
    logic signed [25:0] full;
    logic               unused_ok;

    // Every term is carried at 26 bits, which holds the worst-case sum exactly
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                e[i][j] = {{18{matriz_A[elem(i, j) + ELEM_W - 1]}},
                           matriz_A[elem(i, j) +: ELEM_W]};
            end
        end
        cof0 = e[1][1] * e[2][2] - e[1][2] * e[2][1];
        cof1 = e[1][0] * e[2][2] - e[1][2] * e[2][0];
        cof2 = e[1][0] * e[2][1] - e[1][1] * e[2][0];
        full = e[0][0] * cof0 - e[0][1] * cof1 + e[0][2] * cof2;
    end

    assign det       = full[ELEM_W-1:0];
    assign overflow  = (full > MAX8) || (full < MIN8);
    assign unused_ok = ^{clk, matriz_A};

endmodule

// File: rtl/matriz_determ4x4_seq.sv
// Sequential 4x4 determinant by Laplace expansion along row 0, evaluating
// one 3x3 minor per cycle through a shared matriz_determ3x3 instance.
module matriz_determ4x4_seq
    import matriz_determ4x4_seq_pkg::*;
#(
    parameter int ACC_W = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAT_W-1:0]   matriz_A,
    output logic               busy,
    output logic               done,
    output logic [ELEM_W-1:0]  det,
    output logic               overflow
);

    localparam logic signed [ACC_W-1:0] ACC_MAX8 = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] ACC_MIN8 = ACC_W'(-128);

    state_t                   state, state_next;
    logic [1:0]               k;
    logic signed [ACC_W-1:0]  acc;
    logic                     ovf_acc;
    logic signed [7:0]        m_reg [4][4];

    logic [MAT_W-1:0]         minor_vec;
    logic [ELEM_W-1:0]        det3;
    logic                     ovf3;
    logic signed [7:0]        a0k;
    logic signed [15:0]       a_ext, d_ext, prod;
    logic signed [ACC_W-1:0]  term, acc_sum;
    logic                     res_ovf;
    logic                     unused_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (k == 2'd3) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Minor k: rows 1..3 of the latched matrix with column k skipped
    always_comb begin
        minor_vec = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                minor_vec[elem(r, c) +: ELEM_W] = m_reg[r + 1][(c < int'(k)) ? c : c + 1];
            end
        end
    end

    matriz_determ3x3 u_determ3x3 (
        .clk      (clk),
        .matriz_A (minor_vec),
        .det      (det3),
        .overflow (ovf3)
    );

    always_comb begin
        a0k     = m_reg[0][k];
        a_ext   = {{8{a0k[7]}}, a0k};
        d_ext   = {{8{det3[7]}}, det3};
        prod    = a_ext * d_ext;
        term    = {{(ACC_W - 16){prod[15]}}, prod};
        acc_sum = k[0] ? (acc - term) : (acc + term);
        res_ovf = (acc > ACC_MAX8) || (acc < ACC_MIN8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= 2'd0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            det      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    m_reg[i][j] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k       <= 2'd0;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            for (int j = 0; j < 4; j++) begin
                                m_reg[i][j] <= matriz_A[elem(i, j) +: ELEM_W];
                            end
                        end
                    end
                end
                CALC: begin
                    acc <= acc_sum;
                    // An overflowing minor only matters if its coefficient is non-zero
                    if (ovf3 && (a0k != 8'sd0)) begin
                        ovf_acc <= 1'b1;
                    end
                    if (k != 2'd3) begin
                        k <= k + 2'd1;
                    end
                end
                FIN: begin
                    det      <= acc[ELEM_W-1:0];
                    overflow <= ovf_acc | res_ovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign unused_ok = ^matriz_A;

endmodule

// File: tb/tb_matriz_determ4x4_seq.sv
// Directed self-checking bench for matriz_determ4x4_seq using immediate
// assertions against hand-computed determinants and handshake timing.
module tb_matriz_determ4x4_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [199:0] matriz_A;
    logic         busy;
    logic         done;
    logic [7:0]   det;
    logic         overflow;

    logic [199:0] mat;
    int           checks;
    int           failures;
    int           edges;
    int           busyCnt;
    int           pulses;

    matriz_determ4x4_seq #(.ACC_W(18)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .matriz_A (matriz_A),
        .busy     (busy),
        .done     (done),
        .det      (det),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setElem(input int i, input int j, input logic [7:0] v);
        mat[i*40 + j*8 +: 8] = v;
    endtask

    task automatic setDiag(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
        mat = '0;
        setElem(0, 0, d0);
        setElem(1, 1, d1);
        setElem(2, 2, d2);
        setElem(3, 3, d3);
    endtask

    // Presents the matrix with a one-cycle start; returns at the negedge after E0
    task automatic applyStimulus(input logic [199:0] m);
        @(negedge clk);
        matriz_A = m;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic waitDone(output int nEdges, output int nBusy);
        nEdges = 0;
        nBusy  = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && nEdges < 20) begin
            @(negedge clk);
            nEdges++;
            if (busy === 1'b1 && done !== 1'b1) nBusy++;
        end
    endtask

    task automatic runCheck(input string tag, input logic [7:0] expDet, input logic expOvf);
        applyStimulus(mat);
        waitDone(edges, busyCnt);
        checkOutput({tag, " latency"}, edges, 5);
        checkOutput({tag, " det"}, {24'h0, det}, {24'h0, expDet});
        checkOutput({tag, " overflow"}, {31'h0, overflow}, {31'h0, expOvf});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        matriz_A = '0;
        mat      = '0;

        #2;
        checkOutput("reset busy", {31'h0, busy}, 0);
        checkOutput("reset done", {31'h0, done}, 0);
        checkOutput("reset det", {24'h0, det}, 0);
        checkOutput("reset overflow", {31'h0, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity, with junk in the ignored row 4 and column 4
        setDiag(8'd1, 8'd1, 8'd1, 8'd1);
        mat[199:160] = {40{1'b1}};
        for (int i = 0; i < 4; i++) setElem(i, 4, 8'h7F);
        applyStimulus(mat);
        waitDone(edges, busyCnt);
        checkOutput("ident latency", edges, 5);
        checkOutput("ident busy cycles", busyCnt, 5);
        checkOutput("ident busy at done", {31'h0, busy}, 0);
        checkOutput("ident det", {24'h0, det}, 32'h01);
        checkOutput("ident overflow", {31'h0, overflow}, 0);
        @(negedge clk);
        checkOutput("ident done width", {31'h0, done}, 0);
        checkOutput("ident det hold", {24'h0, det}, 32'h01);

        setDiag(8'd2, 8'd3, 8'd1, 8'hFF);
        runCheck("diag231m1", 8'hFA, 1'b0);
        setDiag(8'd2, 8'd2, 8'd2, 8'd2);
        runCheck("diag2222", 8'h10, 1'b0);
        setDiag(8'd8, 8'd8, 8'd8, 8'd1);
        runCheck("diag8881", 8'h00, 1'b1);

        // Overflowing minor 0 is multiplied by a00=0 and must be ignored
        mat = '0;
        setElem(0, 1, 8'd1);
        setElem(1, 0, 8'd1);
        setElem(1, 2, 8'd100);
        setElem(2, 3, 8'd100);
        setElem(3, 1, 8'd1);
        setElem(3, 2, 8'd1);
        setElem(3, 3, 8'd1);
        runCheck("zero coef", 8'h64, 1'b0);

        // Start held for three cycles, matrix zeroed right after it is latched
        setDiag(8'd1, 8'd1, 8'd1, 8'd1);
        @(negedge clk);
        matriz_A = mat;
        start    = 1'b1;
        @(negedge clk);
        matriz_A = '0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 2;
        while (done !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("held start latency", edges, 5);
        checkOutput("held start det", {24'h0, det}, 32'h01);
        checkOutput("held start overflow", {31'h0, overflow}, 0);

        // Start in the done cycle is accepted
        setDiag(8'd2, 8'd2, 8'd2, 8'd2);
        matriz_A = mat;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("back2back busy", {31'h0, busy}, 1);
        waitDone(edges, busyCnt);
        checkOutput("back2back latency", edges, 5);
        checkOutput("back2back det", {24'h0, det}, 32'h10);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checkOutput("no queued start", pulses, 0);

        // Reset in the middle of a run aborts it
        setDiag(8'd2, 8'd3, 8'd1, 8'hFF);
        applyStimulus(mat);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort busy", {31'h0, busy}, 0);
        checkOutput("abort done", {31'h0, done}, 0);
        checkOutput("abort det", {24'h0, det}, 0);
        checkOutput("abort overflow", {31'h0, overflow}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checkOutput("abort no done", pulses, 0);
        setDiag(8'd2, 8'd3, 8'd1, 8'hFF);
        runCheck("after abort", 8'hFA, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/matriz_determ4x4_seq.md
Name: matriz_determ4x4_seq

Overview:
- Sequential 4x4 determinant unit for the coprocessor ULA. It sits directly downstream of the existing combinational `matriz_determ3x3` block and consumes its det/overflow outputs.
- Uses Laplace expansion along row 0. One 3x3 minor is evaluated per cycle through a single `matriz_determ3x3` instance, and the signed terms are accumulated.
- Result is an 8-bit two's-complement determinant plus an overflow flag, in the same format as the 3x3 block.

Parameters:
- ACC_W, 18, accumulator width. Must be ≥ 18: worst-case |sum| is 4·128·128.

Ports:
- clk       input   1    system clock, rising edge
- rst_n     input   1    asynchronous active-low reset
- start     input   1    request; sampled only in IDLE
- matriz_A  input   200  5x5 packed matrix, signed 8-bit elements
- busy      output  1    high while a computation is in progress
- done      output  1    one-cycle pulse when det/overflow are updated
- det       output  8    determinant, low 8 bits of the two's-complement result
- overflow  output  1    true determinant is outside [-128,127]

Behaviour:
- Packing: element (i,j) occupies matriz_A[i*40+j*8 +: 8], i.e. row-major, 40 bits per row. Only rows 0..3 and cols 0..3 are used; row 4 and col 4 are ignored.
- Reset (async, rst_n=0):
  - state=IDLE, k=0, acc=0, ovf_acc=0.
  - Outputs: busy=0, done=0, det=8'h00, overflow=0.
  - Reset during CALC/FIN aborts the operation; no done pulse is issued.
- States:
  - IDLE: start=1 → latch matriz_A into an internal register m_reg, k=0, acc=0, ovf_acc=0, go to CALC. start=0 → stay.
  - CALC: apply minor k to the 3x3 instance (see minor build below), then:
    - acc += s_k·a0k·det3, where s_k=+1 for k even and -1 for k odd; a0k and det3 are sign-extended.
    - If ovf3=1 and a0k≠0, set ovf_acc=1. An overflowing minor multiplied by zero is ignored.
    - k==3 → go to FIN; otherwise k++.
  - FIN: det ← acc[7:0]; overflow ← ovf_acc | (acc ∉ [-128,127]); done=1 for this one cycle; go to IDLE.
- Minor build:
  - The minor is formed from rows 1..3 of m_reg with column k removed, remaining columns in ascending order.
  - It is packed into the top-left 3x3 of a 200-bit vector; all other bits are 0.
  - The 3x3 block's clk input is tied to clk.
- Timing:
  - start sampled at edge E0.
  - The four minors accumulate at edges E1..E4.
  - Outputs update and done=1 after E5; latency is 5 cycles, and a new result is available every 6 cycles when start is held.
- busy = (state≠IDLE). It is high after E0 through E5 and already low while done is high.
- Input/output stability:
  - start while busy is ignored and not queued.
  - start in the same cycle done is high (state IDLE) is accepted.
  - Changes on matriz_A after E0 have no effect on the running computation.
- det and overflow hold their last values until the next FIN.
- All arithmetic is signed. The 3x3 product sum is exact within 26 bits, so det3 is valid whenever ovf3=0.

Decomposition:
- Shared package holds:
  - ELEM_W=8, ROW_STRIDE=40, MAT_W=200.
  - The state encoding: IDLE, CALC, FIN (2-bit).
  - An elem(i,j) bit-offset function.
- Sub-module: `matriz_determ3x3` (existing), instantiated once.
- Minor selection stays inline as a combinational mux on k; no further sub-modules.

Test Plan:
1. Identity 4x4, start pulse → done after 5 cycles, det=8'h01, overflow=0; busy high for exactly 5 cycles.
2. diag(2,3,1,-1) → det=8'hFA (-6), overflow=0. diag(2,2,2,2) → det=8'h10, overflow=0.
3. diag(8,8,8,1) → true det 512; det=8'h00, overflow=1.
4. Zero-coefficient minor overflow case:
   - rows r0=[0,1,0,0], r1=[1,0,100,0], r2=[0,0,0,100], r3=[0,1,1,1].
   - minor0=10000 (3x3 overflow, but a00=0); minor1=-100.
   - Required: det=8'h64 (100), overflow=0.
5. Handshake stability: start held high for 3 cycles, and matriz_A changed to zeros at E1 → only one done pulse, result computed from the matrix latched at E0. Then start asserted in the done cycle → second computation begins and its done arrives 5 cycles after that start.
6. rst_n pulled low at E2 of a run → all outputs go to 0 immediately and no done pulse follows. After release, a new start produces a correct result.
